shift_exec_stage: RTL and testbench
===================================

# shift_exec_stage

Two-stage pipelined execute-stage shift unit for the RV32I core. It accepts decoded SLL/SRL/SRA operations over a valid/ready handshake and prepares operands, performing left shifts by bit-reversal around the team's 32-bit right barrel shifter (`barrel_shifter_right_32`). It registers the result and destination tag and hands them to writeback. It sits between the decode/operand-read stage (upstream) and the writeback mux (downstream), and it supports back-pressure and pipeline flush.

## Interface
- No parameters; data width is fixed at 32 and shift amount at 5.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: discard all in-flight operations (branch mispredict / trap).
- `in_valid` in 1: upstream presents an operation.
- `in_ready` out 1: stage can accept; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_op` in 2: 00 SLL, 01 SRL, 11 SRA, 10 reserved (pass-through).
- `in_data` in 32: rs1 value.
- `in_amt` in 5: shift amount, already selected from rs2[4:0] or shamt by decode.
- `in_rd` in 5: destination register tag.
- `out_valid` out 1: result available.
- `out_ready` in 1: writeback accepts; a transfer occurs when `out_valid && out_ready`.
- `out_result` out 32: shifted value.
- `out_rd` out 5: destination tag of `out_result`.

## Operation
- Stage 1 register (S1): holds `s1_valid`, `s1_data`, `s1_amt`, `s1_arith`, `s1_left`, `s1_pass`, `s1_rd`.
  - `s1_data` is `in_data` bit-reversed when op = SLL, otherwise `in_data` as presented.
  - `s1_arith` is 1 only for SRA.
  - `s1_left` is 1 only for SLL.
  - `s1_pass` is 1 only for op 10.
- Stage 2 (combinational into the S2 register):
  - `s1_data` feeds the right shifter with type_shift = `s1_arith` and amt = `s1_amt`.
  - The shifter output is bit-reversed again when `s1_left` is set.
  - When `s1_pass` is set, the value is forced to the unshifted, unreversed original operand.
  - The result is registered into S2 (`out_result`, `out_rd`, `out_valid`).
- Advance rules:
  - `s2_adv = !out_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = s1_adv && !flush && !reset`.
- S2 loads from S1 when `s2_adv`:
  - `out_valid` takes `s1_valid`.
  - The data and tag registers load only when `s1_valid` is 1; otherwise they hold.
- S1 loads when `s1_adv`: `s1_valid` takes `in_valid && in_ready`.
- Stall:
  - While `out_valid && !out_ready`, `out_result` and `out_rd` are held stable.
  - S1 holds when occupied; `in_ready` is 0 when both stages are full.
- Flush:
  - `s1_valid` and `out_valid` clear at that edge.
  - Input is not accepted in a flush cycle.
  - Data registers keep stale values; they are don't-care.
  - Flush overrides `out_ready`: a result presented in the flush cycle counts as not consumed.
- Arithmetic rules:
  - Amount 0 yields `in_data` for every op.
  - SRA replicates bit 31; SRL and SLL fill with zeros.
  - `rd` = 0 is processed normally; writeback discards it.

## Timing
- Reset values:
  - `out_valid` = 0, `out_result` = 32'h0, `out_rd` = 5'h0.
  - `s1_valid` = 0, all S1 data = 0.
  - `in_ready` = 0 while `reset` is high and 1 the first cycle after.
- Latency: an op accepted at edge N has `out_valid` = 1 after edge N+1, provided no back-pressure.
- Throughput: one op per cycle with `out_ready` held high.
- Buffering: at most 2 ops in flight, and no op is lost or duplicated under any `out_ready` pattern.
- Flush arriving during reset is a no-op; reset dominates.
- Reset mid-operation drops all in-flight ops at that edge.
- `in_ready` depends combinationally on `out_ready`; `out_*` are registered only.

## Test plan
- SLL/SRL/SRA of 32'h8000_00F0, amt 4, rd 7, back-to-back with `out_ready` = 1:
  - Outputs on consecutive cycles, 2 cycles after acceptance, in order: 32'h0000_0F00, 32'h0800_000F, 32'hF800_000F, each with `out_rd` = 7.
- Boundaries, 32'hFFFF_FFFF:
  - amt 0 for every op returns 32'hFFFF_FFFF.
  - amt 31: SLL gives 32'h8000_0000, SRL gives 32'h0000_0001, SRA gives 32'hFFFF_FFFF.
  - op 10 with amt 9 returns the operand unchanged.
- Back-pressure: stream 4 ops with `out_ready` = 0 for 5 cycles.
  - `in_ready` drops after 2 accepts.
  - `out_result` stays stable for all 5 cycles.
  - On release, all 4 results appear in order with no gaps, duplicates or losses.
- Flush with both stages full and `out_valid` = 1, `out_ready` = 1:
  - Next cycle `out_valid` = 0 and `in_ready` = 0 during the flush cycle.
  - The next accepted op emerges 2 cycles after acceptance with the correct value.
- Reset asserted with 2 ops in flight:
  - `out_valid` = 0, `out_result` = 0, `out_rd` = 0 after the edge.
  - No stale result appears after `reset` deasserts.
- Randomised ops and `out_ready` against a reference model of the RV32 shifts:
  - Every accepted op yields exactly one matching result, in order.

Source files
------------

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined execute-stage shift unit for the RV32I core.
// Left shifts reuse the right barrel shifter by reversing the operand before and after it.

module barrel_shifter_right_32 (
  input  logic [31:0] data,
  input  logic [4:0]  amt,
  input  logic        type_shift,
  output logic [31:0] result
);

  logic        fill;
  logic [31:0] stage;

  assign fill = type_shift && data[31];

  // Logarithmic shifter: each amount bit shifts by its power of two.
  always_comb begin
    stage = data;
    if (amt[0]) stage = {fill, stage[31:1]};
    if (amt[1]) stage = {{2{fill}}, stage[31:2]};
    if (amt[2]) stage = {{4{fill}}, stage[31:4]};
    if (amt[3]) stage = {{8{fill}}, stage[31:8]};
    if (amt[4]) stage = {{16{fill}}, stage[31:16]};
    result = stage;
  end

endmodule

module shift_exec_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_amt,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd
);

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_PASS = 2'b10,
    OP_SRA  = 2'b11
  } shift_op_e;

  function automatic logic [31:0] bit_reverse(input logic [31:0] value);
    logic [31:0] rev;
    for (int i = 0; i < 32; i++) begin
      rev[i] = value[31-i];
    end
    return rev;
  endfunction

  logic        s1_valid;
  logic [31:0] s1_data;
  logic [4:0]  s1_amt;
  logic        s1_arith;
  logic        s1_left;
  logic        s1_pass;
  logic [4:0]  s1_rd;

  logic        s2_adv;
  logic        s1_adv;
  logic        accept;
  shift_op_e   op;
  logic [31:0] shifted;
  logic [31:0] s2_value;

  assign op     = shift_op_e'(in_op);
  assign s2_adv = !out_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !flush && !reset;
  assign accept = in_valid && in_ready;

  barrel_shifter_right_32 u_shifter (
    .data       (s1_data),
    .amt        (s1_amt),
    .type_shift (s1_arith),
    .result     (shifted)
  );

  // Pass-through operands were stored unreversed, so s1_data is already the original value.
  always_comb begin
    s2_value = shifted;
    if (s1_left) s2_value = bit_reverse(shifted);
    if (s1_pass) s2_value = s1_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_data    <= 32'h0;
      s1_amt     <= 5'h0;
      s1_arith   <= 1'b0;
      s1_left    <= 1'b0;
      s1_pass    <= 1'b0;
      s1_rd      <= 5'h0;
      out_valid  <= 1'b0;
      out_result <= 32'h0;
      out_rd     <= 5'h0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= s2_value;
          out_rd     <= s1_rd;
        end
      end
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_data  <= (op == OP_SLL) ? bit_reverse(in_data) : in_data;
          s1_amt   <= in_amt;
          s1_arith <= (op == OP_SRA);
          s1_left  <= (op == OP_SLL);
          s1_pass  <= (op == OP_PASS);
          s1_rd    <= in_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage: the driver queues hand-computed results,
// a negedge monitor pops and compares every consumed output.

module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cur_exp;
  bit          lat_chk;
  bit          rand_done;
  int          cyc;
  int          total;
  int          bad;

  always #5 clk = ~clk;

  shift_exec_stage dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] a);
    case (op)
      2'b00:   return d << a;
      2'b01:   return d >> a;
      2'b11:   return $unsigned($signed(d) >>> a);
      default: return d;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor first, then record any acceptance that the next rising edge will perform.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output: got %h rd %0d, expected nothing", out_result, out_rd);
      end else begin
        e = sb.pop_front();
        check("result", out_result, e.res);
        check("rd", {27'h0, out_rd}, {27'h0, e.rd});
        if (lat_chk) check("latency", 32'(cyc - e.acc), 32'd2);
      end
    end
    if (reset || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back('{res: cur_exp, rd: in_rd, acc: cyc});
  end

  // Present one op and hold it until the DUT takes it; leaves in_valid low afterwards.
  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] a,
                      input logic [4:0] rd, input logic [31:0] exp);
    bit taken;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = a;
    in_rd    = rd;
    cur_exp  = exp;
    taken    = 1'b0;
    for (int n = 0; n < 200 && !taken; n++) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
    end
    if (!taken) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got in_ready 0, expected 1 within 200 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int vcount;
    logic [1:0]  rop;
    logic [31:0] rdat;
    logic [4:0]  ramt;
    cyc = 0; total = 0; bad = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_data = 32'h0; in_amt = 5'h0; in_rd = 5'h0;
    cur_exp = 32'h0; lat_chk = 1'b0; rand_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {31'h0, in_ready}, 32'd0);
    check("reset_out_valid", {31'h0, out_valid}, 32'd0);
    check("reset_out_result", out_result, 32'h0);
    check("reset_out_rd", {27'h0, out_rd}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", {31'h0, in_ready}, 32'd1);

    $display("[TB] back-to-back SLL/SRL/SRA");
    lat_chk = 1'b1;
    send(2'b00, 32'h8000_00F0, 5'd4, 5'd7, 32'h0000_0F00);
    send(2'b01, 32'h8000_00F0, 5'd4, 5'd7, 32'h0800_000F);
    send(2'b11, 32'h8000_00F0, 5'd4, 5'd7, 32'hF800_000F);
    drain();

    $display("[TB] boundaries and directed shifts");
    send(2'b00, 32'hFFFF_FFFF, 5'd0,  5'd1, 32'hFFFF_FFFF);
    send(2'b01, 32'hFFFF_FFFF, 5'd0,  5'd2, 32'hFFFF_FFFF);
    send(2'b11, 32'hFFFF_FFFF, 5'd0,  5'd3, 32'hFFFF_FFFF);
    send(2'b00, 32'hFFFF_FFFF, 5'd31, 5'd4, 32'h8000_0000);
    send(2'b01, 32'hFFFF_FFFF, 5'd31, 5'd5, 32'h0000_0001);
    send(2'b11, 32'hFFFF_FFFF, 5'd31, 5'd6, 32'hFFFF_FFFF);
    send(2'b10, 32'hFFFF_FFFF, 5'd9,  5'd8, 32'hFFFF_FFFF);
    send(2'b10, 32'h1234_5678, 5'd9,  5'd9, 32'h1234_5678);
    send(2'b00, 32'h1234_5678, 5'd0,  5'd0, 32'h1234_5678);
    send(2'b00, 32'h1234_5678, 5'd12, 5'd10, 32'h4567_8000);
    send(2'b01, 32'h1234_5678, 5'd8,  5'd11, 32'h0012_3456);
    send(2'b11, 32'h7000_0000, 5'd3,  5'd31, 32'h0E00_0000);
    send(2'b11, 32'h8765_4321, 5'd16, 5'd12, 32'hFFFF_8765);
    drain();
    lat_chk = 1'b0;

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    send(2'b00, 32'h0000_0003, 5'd1, 5'd13, 32'h0000_0006);
    send(2'b01, 32'h0000_0300, 5'd8, 5'd14, 32'h0000_0003);
    in_valid = 1'b1; in_op = 2'b11; in_data = 32'hF000_0000; in_amt = 5'd4;
    in_rd = 5'd15; cur_exp = 32'hFF00_0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", {31'h0, in_ready}, 32'd0);
      check("stall_out_valid", {31'h0, out_valid}, 32'd1);
      check("stall_out_result", out_result, 32'h0000_0006);
      check("stall_out_rd", {27'h0, out_rd}, 32'd13);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(2'b11, 32'hF000_0000, 5'd4, 5'd15, 32'hFF00_0000);
    send(2'b10, 32'hCAFE_F00D, 5'd5, 5'd16, 32'hCAFE_F00D);
    drain();

    $display("[TB] flush");
    send(2'b00, 32'h0000_0001, 5'd1, 5'd17, 32'h0000_0002);
    send(2'b00, 32'h0000_0001, 5'd2, 5'd18, 32'h0000_0004);
    check("pre_flush_out_valid", {31'h0, out_valid}, 32'd1);
    flush = 1'b1;
    in_valid = 1'b1; in_op = 2'b01; in_data = 32'h0000_F000; in_amt = 5'd12;
    in_rd = 5'd19; cur_exp = 32'h0000_000F;
    #1;
    check("flush_in_ready", {31'h0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("post_flush_out_valid", {31'h0, out_valid}, 32'd0);
    lat_chk = 1'b1;
    send(2'b01, 32'h0000_F000, 5'd12, 5'd19, 32'h0000_000F);
    drain();
    lat_chk = 1'b0;

    $display("[TB] reset mid-operation");
    out_ready = 1'b0;
    send(2'b00, 32'h0000_00FF, 5'd4, 5'd20, 32'h0000_0FF0);
    send(2'b01, 32'h0000_00FF, 5'd4, 5'd21, 32'h0000_000F);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_rd", {27'h0, out_rd}, 32'd0);
    check("rst_in_ready", {31'h0, in_ready}, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    vcount = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("stale_after_reset", 32'(vcount), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] randomised ops and out_ready");
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          rop  = 2'($urandom_range(0, 3));
          rdat = $urandom;
          ramt = 5'($urandom_range(0, 31));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rop, rdat, ramt, 5'($urandom_range(0, 31)), ref_shift(rop, rdat, ramt));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
